execute_hazard_ctrl: RTL and testbench
======================================

// Module: execute_hazard_ctrl
// PURPOSE
// Hazard/forwarding controller for the Execute stage. Tracks destination registers of the two
// instructions ahead of Execute and drives the Execute operand-forwarding selects, a load-use
// stall and a control-flow flush. Sits beside Execute and drives its Data_ASel/Data_BSel inputs.
// Sequences bubbles into its own history so forwarding stays correct across stalls and flushes.
// PARAMETERS
// FLUSH_CYCLES  1  extra flush cycles held after the br_taken cycle (1..3)
// CNT_W         2  width of flush counter; must hold FLUSH_CYCLES
// PORTS
// clk          in   1   clock, rising edge
// rst_n        in   1   reset, asynchronous, active-low
// id_inst      in   32  instruction entering Execute this cycle (same as Execute Inst_Decode)
// id_valid     in   1   id_inst is a real instruction (0 = bubble)
// br_taken     in   1   Execute resolved a taken branch/JAL/JALR this cycle
// data_a_sel   out  2   rs1 select: 00 REG, 10 DATA_D (1 ahead), 11 DATA_D_ff1 (2 ahead)
// data_b_sel   out  2   rs2 select, same encoding
// stall        out  1   hold Fetch/Decode, bubble Execute this cycle
// flush        out  1   kill instructions younger than Execute this cycle
// BEHAVIOUR
// - Reset (rst_n=0, async): history cleared (both entries invalid), state RUN, counter 0;
//   data_*_sel=00, stall=0, flush=br_taken (0 while br_taken low). Outputs combinational off regs.
// - History: h0 = instr 1 ahead (result = DATA_D), h1 = 2 ahead (DATA_D_ff1). Entry={rd[4:0],wr,ld}.
//   Decode: wr=1 for OP,OP-IMM,LOAD,LUI,AUIPC,JAL,JALR with rd!=0; ld=1 for LOAD. rd=0 never wr.
// - rs usage: rs1 for OP,OP-IMM,LOAD,STORE,BRANCH,JALR; rs2 for OP,STORE,BRANCH; else unused (sel 00).
// - Forward (used rs, id_valid, not flush): rs==h0.rd & h0.wr -> 10; else rs==h1.rd & h1.wr -> 11;
//   else 00. h0 has priority over h1. rs==0 always 00.
// - Load-use: h0.ld & h0.wr & used rs matches h0.rd -> stall=1 for exactly 1 cycle; sels forced 00;
//   bubble enters h0, h0 shifts to h1; next cycle same id_inst forwards 11 from h1.
// - Every edge: h1<=h0; h0<=entry(id_inst) if id_valid & !stall & !flush, else bubble (wr=0,ld=0).
// - FSM: RUN -> FLUSH on br_taken (counter<=FLUSH_CYCLES); FLUSH decrements each cycle, -> RUN when
//   counter reaches 1 then 0. flush = br_taken | (state==FLUSH).
// - During flush: stall=0, sels 00, h0 gets bubble; the br_taken instruction itself is already in
//   history (it entered before) and still forwards (JAL/JALR link value).
// - br_taken and load-use same cycle: flush wins, stall=0. br_taken while in FLUSH: counter reloads.
// - stall and flush never both 1. No interaction on back-to-back stalls: stall is bounded to 1 cycle
//   per load because the bubble removes the h0 match.
// - Reset mid-flush/mid-stall: returns to RUN, history empty, no residual stall/flush.
// TESTING
// 1 addi x5,x0,1 then add x6,x5,x5 -> second cycle data_a_sel=10, data_b_sel=10, stall=0.
// 2 addi x5; nop(id_valid=1 addi x0); sub x7,x5,x1 -> data_a_sel=11, data_b_sel=00.
// 3 lw x5,0(x1) then add x6,x5,x2 -> stall=1 one cycle, sels 00; next cycle data_a_sel=11, stall=0.
// 4 br_taken=1 with FLUSH_CYCLES=1 -> flush=1 that cycle and next, then 0; no forwarding from killed.
// 5 add x0,x1,x2 then add x3,x0,x0 -> sels 00 (x0 never forwarded); addi x5 twice then use x5 -> 10.
// 6 assert rst_n=0 mid-stall and mid-flush (async, off-edge) -> stall=0, flush=0, sels 00 immediately.

Source files
------------

// File: rtl/execute_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding selects, load-use stall and
// control-flow flush, driven from a two-deep history of destination registers.
module execute_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        br_taken,
    output logic [1:0]  data_a_sel,
    output logic [1:0]  data_b_sel,
    output logic        stall,
    output logic        flush
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned SEL_W = 2;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

    localparam logic [SEL_W-1:0] SEL_REG    = 2'b00;
    localparam logic [SEL_W-1:0] SEL_D      = 2'b10;
    localparam logic [SEL_W-1:0] SEL_D_FF1  = 2'b11;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             ld;
    } hist_t;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    localparam hist_t BUBBLE = '{rd: '0, wr: 1'b0, ld: 1'b0};

    hist_t            h0_q, h0_d;
    hist_t            h1_q, h1_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd, rs1, rs2;
    logic             op_wr, op_ld, use_rs1, use_rs2;
    logic             a_h0, a_h1, b_h0, b_h1;
    logic             load_use;
    hist_t            id_entry;
    logic             unused_inst_bits;

    assign opcode           = id_inst[6:0];
    assign rd               = id_inst[11:7];
    assign rs1              = id_inst[19:15];
    assign rs2              = id_inst[24:20];
    assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:12]};

    // Instruction class decode: which operands are read, whether rd is written / loaded.
    always_comb begin
        op_wr   = 1'b0;
        op_ld   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_OP:     begin op_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_OP_IMM: begin op_wr = 1'b1; use_rs1 = 1'b1; end
            OPC_LOAD:   begin op_wr = 1'b1; op_ld = 1'b1; use_rs1 = 1'b1; end
            OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_LUI:    op_wr = 1'b1;
            OPC_AUIPC:  op_wr = 1'b1;
            OPC_JAL:    op_wr = 1'b1;
            OPC_JALR:   begin op_wr = 1'b1; use_rs1 = 1'b1; end
            default:    ;
        endcase
    end

    always_comb begin
        id_entry    = BUBBLE;
        id_entry.rd = rd;
        id_entry.wr = op_wr && (rd != '0);
        id_entry.ld = op_ld && (rd != '0);
    end

    // Match the operands against history; x0 is never a forwarding source.
    always_comb begin
        a_h0 = id_valid && use_rs1 && (rs1 != '0) && h0_q.wr && (rs1 == h0_q.rd);
        a_h1 = id_valid && use_rs1 && (rs1 != '0) && h1_q.wr && (rs1 == h1_q.rd);
        b_h0 = id_valid && use_rs2 && (rs2 != '0) && h0_q.wr && (rs2 == h0_q.rd);
        b_h1 = id_valid && use_rs2 && (rs2 != '0) && h1_q.wr && (rs2 == h1_q.rd);
        load_use = h0_q.ld && (a_h0 || b_h0);
    end

    // Flush dominates stall; both force the register-file selects.
    always_comb begin
        flush      = br_taken || (state_q == ST_FLUSH);
        stall      = load_use && !flush;
        data_a_sel = SEL_REG;
        data_b_sel = SEL_REG;
        if (!flush && !stall) begin
            if (a_h0)      data_a_sel = SEL_D;
            else if (a_h1) data_a_sel = SEL_D_FF1;
            if (b_h0)      data_b_sel = SEL_D;
            else if (b_h1) data_b_sel = SEL_D_FF1;
        end
    end

    always_comb begin
        h1_d = h0_q;
        h0_d = (id_valid && !stall && !flush) ? id_entry : BUBBLE;
    end

    // Flush sequencer: a taken branch (re)loads the counter for the trailing flush cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (br_taken) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                if (br_taken) begin
                    cnt_d = CNT_W'(FLUSH_CYCLES);
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0_q    <= BUBBLE;
            h1_q    <= BUBBLE;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_execute_hazard_ctrl.sv
// Scoreboard bench for execute_hazard_ctrl: expected selects/stall/flush are queued at drive
// time and compared on the falling edge when the combinational outputs have settled.
module tb_execute_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        br_taken;
    logic [1:0]  data_a_sel;
    logic [1:0]  data_b_sel;
    logic        stall;
    logic        flush;

    int n_chk  = 0;
    int n_pass = 0;
    int n_step = 0;
    logic [5:0] exp_q[$];

    execute_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_inst    (id_inst),
        .id_valid   (id_valid),
        .br_taken   (br_taken),
        .data_a_sel (data_a_sel),
        .data_b_sel (data_b_sel),
        .stall      (stall),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_sub(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] i_jal(input logic [4:0] rd);
        return {20'd0, rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] i_lui(input logic [4:0] rd);
        return {20'h00001, rd, 7'b0110111};
    endfunction

    // One cycle of stimulus; expectation is {a_sel, b_sel, stall, flush}.
    task automatic drive(input logic [31:0] inst, input logic v, input logic br,
                         input logic [1:0] ea, input logic [1:0] eb, input logic es, input logic ef);
        @(posedge clk);
        #1;
        id_inst  = inst;
        id_valid = v;
        br_taken = br;
        exp_q.push_back({ea, eb, es, ef});
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            n_step++;
            chk($sformatf("a_sel#%0d", n_step), 32'(data_a_sel), 32'(e[5:4]));
            chk($sformatf("b_sel#%0d", n_step), 32'(data_b_sel), 32'(e[3:2]));
            chk($sformatf("stall#%0d", n_step), 32'(stall),      32'(e[1]));
            chk($sformatf("flush#%0d", n_step), 32'(flush),      32'(e[0]));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        id_inst  = 32'h0;
        id_valid = 1'b0;
        br_taken = 1'b0;
        #3;
        chk("rst_a_sel", 32'(data_a_sel), 32'd0);
        chk("rst_b_sel", 32'(data_b_sel), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        br_taken = 1'b1;
        #1;
        chk("rst_flush_follows_br", 32'(flush), 32'd1);
        br_taken = 1'b0;
        #18;
        rst_n = 1'b1;

        // Forward from one ahead on both operands
        drive(i_addi(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_add(5'd6, 5'd5, 5'd5),   1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
        bubbles(2);

        // Forward from two ahead across a nop
        drive(i_addi(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_addi(5'd0, 5'd0, 12'd0), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_sub(5'd7, 5'd5, 5'd1),   1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0);
        bubbles(2);

        // Load-use: one stall cycle, then the same instruction forwards from two ahead
        drive(i_lw(5'd5, 5'd1),          1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_add(5'd6, 5'd5, 5'd2),   1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
        drive(i_add(5'd6, 5'd5, 5'd2),   1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0);
        bubbles(2);

        // Load two ahead needs no stall; rs2-only use through a store also stalls
        drive(i_lw(5'd8, 5'd1),          1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_addi(5'd0, 5'd0, 12'd0), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_add(5'd9, 5'd8, 5'd8),   1'b1, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
        drive(i_lw(5'd11, 5'd9),         1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
        drive(i_sw(5'd11, 5'd2),         1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
        drive(i_sw(5'd11, 5'd2),         1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0);
        bubbles(2);

        // Taken branch: flush that cycle and one more; killed instructions never forward
        drive(i_addi(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_jal(5'd1),               1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_add(5'd6, 5'd1, 5'd5),   1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
        drive(i_add(5'd7, 5'd1, 5'd1),   1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        drive(i_add(5'd8, 5'd6, 5'd7),   1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        bubbles(2);

        // Load-use coinciding with br_taken: flush wins
        drive(i_lw(5'd5, 5'd1),          1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_add(5'd6, 5'd5, 5'd5),   1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
        drive(i_add(5'd6, 5'd5, 5'd5),   1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        drive(i_add(5'd6, 5'd5, 5'd5),   1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        bubbles(2);

        // br_taken again while flushing reloads the counter
        drive(32'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
        drive(32'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        // x0 is never forwarded; newest writer has priority; LUI writes
        drive(i_add(5'd0, 5'd1, 5'd2),   1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_add(5'd3, 5'd0, 5'd0),   1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_addi(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_addi(5'd5, 5'd0, 12'd2), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_add(5'd6, 5'd5, 5'd0),   1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
        drive(i_lui(5'd9),               1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive(i_add(5'd10, 5'd2, 5'd9),  1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
        drive(i_sw(5'd10, 5'd9),         1'b1, 1'b0, 2'b11, 2'b10, 1'b0, 1'b0);
        bubbles(2);
        drain();

        // Asynchronous reset in the middle of a stall
        drive(i_lw(5'd5, 5'd1), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        drain();
        @(posedge clk);
        #1;
        id_inst  = i_add(5'd6, 5'd5, 5'd5);
        id_valid = 1'b1;
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_stall_flush", 32'(flush), 32'd0);
        chk("rst_mid_stall_a", 32'(data_a_sel), 32'd0);
        chk("rst_mid_stall_b", 32'(data_b_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        id_valid = 1'b0;

        // Asynchronous reset in the middle of a flush
        @(posedge clk);
        #1;
        br_taken = 1'b1;
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        #1;
        chk("pre_rst_flush", 32'(flush), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flush", 32'(flush), 32'd0);
        chk("rst_mid_flush_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_flush", 32'(flush), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
